cdecn_dp: RTL and testbench
===========================

CDECN_DP -- requirements
Module: cdecn_dp

Interface
REQ-001 Parameter WIDTH, default 8, datapath/register/bus width (>=8).
REQ-002 Parameter PC_RESET, default 0, PC value after reset.
REQ-003 Parameter TIMEOUT, default 255, maximum memory wait cycles before abort (1..2^16-1).
REQ-004 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Ports io_in in WIDTH / io_out out WIDTH  input port, output port.
REQ-007 Ports adrs out WIDTH / data_in in WIDTH / data_out out WIDTH  memory address, read data, write data.
REQ-008 Ports mem_req out 1 / mem_we out 1 / mem_ack in 1  memory handshake.
REQ-009 Ports I out WIDTH / flags out 4 / stall out 1  instruction register, flags {V,S,Z,Cy}, memory-wait indicator.
REQ-010 Port ctrl  in  17  control word {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]}.
REQ-011 Ports resad in 8 / resdt out WIDTH  debug monitor address and data.

Function
REQ-012 xsrc: 0 PC, 1 A, 2 B, 3 C, 4 R, 5 RDR, 6 FLG, 8 IPORT; all other codes drive all-ones.
REQ-013 xdst: 0 PC, 1 A, 2 B, 3 C, 4 MAR, 5 WDR, 6 T, 7 I, 8 OPORT, 9 FLG (new); all other codes write nothing.
REQ-014 rwr=1 loads R from the ALU result; fwr=1 loads V,S,Z,Cy from the ALU; both are combined with the xdst write in the same cycle.
REQ-015 If fwr=1 and xdst=9 in the same cycle, fwr wins for bits 4:1; bit 0 takes XBUS[0].
REQ-016 FLG layout: bit0 mem_err, bit1 Cy, bit2 Z, bit3 S, bit4 V; all other bits read as 0.
REQ-017 ALU operands X=XBUS, Y=T, cin=Cy. Ops: 0 X, 1 X+Y, 2 X+Y+cin, 3 X-Y, 4 X-Y-cin, 5 AND, 6 OR, 7 XOR, 8 NOT X, 9 SHL, 10 SHR, 11 ASR; all other ops pass X.
REQ-018 ALU flags: Cy = carry out (borrow for subtraction; shifted-out bit for shifts); Z = result==0; S = result MSB; V = two's-complement overflow for ops 1-4, 0 otherwise.
REQ-019 IPORT samples io_in every cycle; io_out is the OPORT register.
REQ-020 adrs=MAR and data_out=WDR at all times.
REQ-021 Memory FSM states: IDLE, RD_WAIT, WR_WAIT. mmrw=10 in IDLE goes to RD_WAIT; mmrw=01 in IDLE goes to WR_WAIT; mmrw=00/11 stays in IDLE.
REQ-022 mem_req = (state!=IDLE); mem_we = (state==WR_WAIT); stall = mem_req; all are registered-state decodes, so the first mem_req appears one cycle after the issue cycle.
REQ-023 A WAIT state with mem_ack=1 returns to IDLE; in RD_WAIT, RDR loads data_in on that edge.
REQ-024 A 16-bit wait counter clears on issue and increments each WAIT cycle without ack; reaching TIMEOUT returns to IDLE, sets mem_err, and leaves RDR unchanged.
REQ-025 While stall=1, all ctrl-driven writes (xdst, rwr, fwr, mmrw) are suppressed; IPORT still samples.
REQ-026 mem_ack while in IDLE is ignored.
REQ-027 mem_err is sticky and is cleared only by xdst=9 with XBUS[0]=0, or by reset.
REQ-028 resdt map: 00 PC, 01 I, 02 T, 03 R, 04 MAR, 05 data_in, 06 RDR, 07 WDR, 08 A, 09 B, 0A C, 0D FLG, 0E XBUS, 0F IPORT, 10 FSM state, 11 wait counter (both zero-extended); other addresses return 0. This is a plain combinational mux with no tri-state.

Reset
REQ-029 On reset, PC is set to PC_RESET; all other registers, OPORT, FLG and the wait counter are cleared to 0; the FSM goes to IDLE; mem_req, mem_we and stall are 0.
REQ-030 Reset asserted mid-transaction drops mem_req asynchronously; RDR is cleared and no late ack is captured.

Structure
REQ-031 Package cdecn_pkg holds the xsrc/xdst codes, ALU op codes, FLG bit indices and the FSM state enum.
REQ-032 The ALU is a single sub-module, cdecn_alu, parameterised by WIDTH; the registers, FSM and monitor are inline.

Verification
REQ-033 WIDTH=8, A=0x7F, T=0x01, aluop=1, rwr=fwr=1 -> R=0x80, flags V=1,S=1,Z=0,Cy=0.
REQ-034 MAR=0x20, mmrw=10, mem_ack asserted 3 cycles after mem_req rises with data_in=0x5A -> RDR=0x5A; stall high for exactly 3 cycles; back to IDLE.
REQ-035 Read with mem_ack held low, TIMEOUT=4 -> return to IDLE after 4 wait cycles, FLG bit0=1, RDR unchanged; xdst=9 with XBUS=0 -> FLG=0.
REQ-036 During WR_WAIT, ctrl xdst=1, xsrc=7 -> A unchanged; after ack, the same ctrl -> A=0xFF.
REQ-037 Reset asserted while in RD_WAIT -> mem_req=0 immediately, PC=PC_RESET; a subsequent ack leaves RDR at 0.
REQ-038 WIDTH=16, resad=0x11 during a wait -> resdt equals the cycle count; resad=0x30 -> 0x0000.

Source files
------------

// File: rtl/cdecn_pkg.sv
// Shared encodings for the cdecn datapath: bus codes, ALU ops, FLG bits, memory FSM.
package cdecn_pkg;

  localparam int unsigned CTRL_W = 17;
  localparam int unsigned FLG_W  = 5;
  localparam int unsigned WCNT_W = 16;

  localparam logic [3:0] SRC_PC    = 4'd0;
  localparam logic [3:0] SRC_A     = 4'd1;
  localparam logic [3:0] SRC_B     = 4'd2;
  localparam logic [3:0] SRC_C     = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_RDR   = 4'd5;
  localparam logic [3:0] SRC_FLG   = 4'd6;
  localparam logic [3:0] SRC_IPORT = 4'd8;

  localparam logic [3:0] DST_PC    = 4'd0;
  localparam logic [3:0] DST_A     = 4'd1;
  localparam logic [3:0] DST_B     = 4'd2;
  localparam logic [3:0] DST_C     = 4'd3;
  localparam logic [3:0] DST_MAR   = 4'd4;
  localparam logic [3:0] DST_WDR   = 4'd5;
  localparam logic [3:0] DST_T     = 4'd6;
  localparam logic [3:0] DST_I     = 4'd7;
  localparam logic [3:0] DST_OPORT = 4'd8;
  localparam logic [3:0] DST_FLG   = 4'd9;

  localparam logic [4:0] ALU_PASS = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADC  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SBB  = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_NOT  = 5'd8;
  localparam logic [4:0] ALU_SHL  = 5'd9;
  localparam logic [4:0] ALU_SHR  = 5'd10;
  localparam logic [4:0] ALU_ASR  = 5'd11;

  localparam int unsigned FLG_ERR = 0;
  localparam int unsigned FLG_CY  = 1;
  localparam int unsigned FLG_Z   = 2;
  localparam int unsigned FLG_S   = 3;
  localparam int unsigned FLG_V   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [3:0] xdst;
    logic [4:0] aluop;
    logic [3:0] xsrc;
  } ctrl_t;

endpackage

// File: rtl/cdecn_alu.sv
// Combinational ALU: X op Y with carry-in; flags returned as {V,S,Z,Cy}.
module cdecn_alu
  import cdecn_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] res_c,
  output logic [3:0]       flags_c
);

  localparam int unsigned WX  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] ext;
  logic           cy;
  logic           v;

  // Subtraction borrows show up as the extended top bit.
  always_comb begin
    ext   = '0;
    res_c = x;
    cy    = 1'b0;
    v     = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: begin
        ext   = {1'b0, x} + {1'b0, y} + WX'(cin & (op == ALU_ADC));
        res_c = ext[MSB:0];
        cy    = ext[WIDTH];
        v     = (x[MSB] == y[MSB]) && (res_c[MSB] != x[MSB]);
      end
      ALU_SUB, ALU_SBB: begin
        ext   = {1'b0, x} - {1'b0, y} - WX'(cin & (op == ALU_SBB));
        res_c = ext[MSB:0];
        cy    = ext[WIDTH];
        v     = (x[MSB] != y[MSB]) && (res_c[MSB] != x[MSB]);
      end
      ALU_AND: res_c = x & y;
      ALU_OR:  res_c = x | y;
      ALU_XOR: res_c = x ^ y;
      ALU_NOT: res_c = ~x;
      ALU_SHL: begin
        res_c = {x[MSB-1:0], 1'b0};
        cy    = x[MSB];
      end
      ALU_SHR: begin
        res_c = {1'b0, x[MSB:1]};
        cy    = x[0];
      end
      ALU_ASR: begin
        res_c = {x[MSB], x[MSB:1]};
        cy    = x[0];
      end
      default: res_c = x;
    endcase
  end

  assign flags_c = {v, res_c[MSB], (res_c == '0), cy};

endmodule

// File: rtl/cdecn_dp.sv
// Microcoded datapath: register file on XBUS, ALU, memory handshake FSM with timeout, debug monitor.
module cdecn_dp
  import cdecn_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PC_RESET = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  io_in,
  output logic [WIDTH-1:0]  io_out,
  output logic [WIDTH-1:0]  adrs,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  I,
  output logic [3:0]        flags,
  output logic              stall,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [7:0]        resad,
  output logic [WIDTH-1:0]  resdt
);

  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(TIMEOUT);

  ctrl_t cw;
  assign cw = ctrl_t'(ctrl);

  logic [WIDTH-1:0]  pc_q, pc_d, i_q, i_d, t_q, t_d, r_q, r_d;
  logic [WIDTH-1:0]  mar_q, mar_d, rdr_q, rdr_d, wdr_q, wdr_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0]  oport_q, oport_d, iport_q, iport_d;
  logic [FLG_W-1:0]  flg_q, flg_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  mem_state_e        state_q, state_d;

  logic [WIDTH-1:0]  xbus;
  logic [WIDTH-1:0]  alu_res;
  logic [3:0]        alu_flags;

  always_comb begin
    case (cw.xsrc)
      SRC_PC:    xbus = pc_q;
      SRC_A:     xbus = a_q;
      SRC_B:     xbus = b_q;
      SRC_C:     xbus = c_q;
      SRC_R:     xbus = r_q;
      SRC_RDR:   xbus = rdr_q;
      SRC_FLG:   xbus = WIDTH'(flg_q);
      SRC_IPORT: xbus = iport_q;
      default:   xbus = '1;
    endcase
  end

  cdecn_alu #(.WIDTH(WIDTH)) u_alu (
    .x       (xbus),
    .y       (t_q),
    .cin     (flg_q[FLG_CY]),
    .op      (cw.aluop),
    .res_c   (alu_res),
    .flags_c (alu_flags)
  );

  assign wcnt_inc = wcnt_q + WCNT_W'(1);

  // Next-state: memory FSM first, then ctrl writes which are frozen while stalled.
  always_comb begin
    pc_d    = pc_q;
    i_d     = i_q;
    t_d     = t_q;
    r_d     = r_q;
    mar_d   = mar_q;
    rdr_d   = rdr_q;
    wdr_d   = wdr_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    oport_d = oport_q;
    iport_d = io_in;
    flg_d   = flg_q;
    wcnt_d  = wcnt_q;
    state_d = state_q;

    case (state_q)
      ST_IDLE: begin
        if (cw.mmrw == 2'b10) begin
          state_d = ST_RD_WAIT;
          wcnt_d  = '0;
        end else if (cw.mmrw == 2'b01) begin
          state_d = ST_WR_WAIT;
          wcnt_d  = '0;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          if (state_q == ST_RD_WAIT) rdr_d = data_in;
        end else if (wcnt_inc == TMO) begin
          state_d        = ST_IDLE;
          wcnt_d         = wcnt_inc;
          flg_d[FLG_ERR] = 1'b1;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE) begin
      if (cw.rwr) r_d = alu_res;
      case (cw.xdst)
        DST_PC:    pc_d    = xbus;
        DST_A:     a_d     = xbus;
        DST_B:     b_d     = xbus;
        DST_C:     c_d     = xbus;
        DST_MAR:   mar_d   = xbus;
        DST_WDR:   wdr_d   = xbus;
        DST_T:     t_d     = xbus;
        DST_I:     i_d     = xbus;
        DST_OPORT: oport_d = xbus;
        DST_FLG:   flg_d   = xbus[FLG_W-1:0];
        default:   ;
      endcase
      // ALU flags override the bus value; mem_err still comes from XBUS[0].
      if (cw.fwr) flg_d[FLG_V:FLG_CY] = alu_flags;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= WIDTH'(PC_RESET);
      i_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      mar_q   <= '0;
      rdr_q   <= '0;
      wdr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      oport_q <= '0;
      iport_q <= '0;
      flg_q   <= '0;
      wcnt_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      pc_q    <= pc_d;
      i_q     <= i_d;
      t_q     <= t_d;
      r_q     <= r_d;
      mar_q   <= mar_d;
      rdr_q   <= rdr_d;
      wdr_q   <= wdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      oport_q <= oport_d;
      iport_q <= iport_d;
      flg_q   <= flg_d;
      wcnt_q  <= wcnt_d;
      state_q <= state_d;
    end
  end

  assign mem_req  = (state_q != ST_IDLE);
  assign mem_we   = (state_q == ST_WR_WAIT);
  assign stall    = mem_req;
  assign adrs     = mar_q;
  assign data_out = wdr_q;
  assign io_out   = oport_q;
  assign I        = i_q;
  assign flags    = flg_q[FLG_V:FLG_CY];

  always_comb begin
    case (resad)
      8'h00:   resdt = pc_q;
      8'h01:   resdt = i_q;
      8'h02:   resdt = t_q;
      8'h03:   resdt = r_q;
      8'h04:   resdt = mar_q;
      8'h05:   resdt = data_in;
      8'h06:   resdt = rdr_q;
      8'h07:   resdt = wdr_q;
      8'h08:   resdt = a_q;
      8'h09:   resdt = b_q;
      8'h0A:   resdt = c_q;
      8'h0D:   resdt = WIDTH'(flg_q);
      8'h0E:   resdt = xbus;
      8'h0F:   resdt = iport_q;
      8'h10:   resdt = WIDTH'(state_q);
      8'h11:   resdt = WIDTH'(wcnt_q);
      default: resdt = '0;
    endcase
  end

endmodule

// File: tb/tb_cdecn_dp.sv
// Directed bench for cdecn_dp: an 8-bit instance (TIMEOUT=4) and a 16-bit instance for the monitor.
module tb_cdecn_dp;
  import cdecn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  io_in8, io_out8, adrs8, data_in8, data_out8, i8, resdt8, resad8;
  logic        req8, we8, ack8, stall8;
  logic [3:0]  flags8;
  logic [16:0] ctrl8;

  logic [15:0] io_in16, io_out16, adrs16, data_in16, data_out16, i16, resdt16;
  logic [7:0]  resad16;
  logic        req16, we16, ack16, stall16;
  logic [3:0]  flags16;
  logic [16:0] ctrl16;

  int checks = 0;
  int errors = 0;

  localparam logic [16:0] NOP = {2'b00, 1'b0, 1'b0, 4'hF, 5'd0, 4'd0};

  cdecn_dp #(.WIDTH(8), .PC_RESET(8'h10), .TIMEOUT(4)) u8 (
    .clock(clk), .reset(rst), .io_in(io_in8), .io_out(io_out8), .adrs(adrs8),
    .data_in(data_in8), .data_out(data_out8), .mem_req(req8), .mem_we(we8),
    .mem_ack(ack8), .I(i8), .flags(flags8), .stall(stall8), .ctrl(ctrl8),
    .resad(resad8), .resdt(resdt8)
  );

  cdecn_dp #(.WIDTH(16)) u16 (
    .clock(clk), .reset(rst), .io_in(io_in16), .io_out(io_out16), .adrs(adrs16),
    .data_in(data_in16), .data_out(data_out16), .mem_req(req16), .mem_we(we16),
    .mem_ack(ack16), .I(i16), .flags(flags16), .stall(stall16), .ctrl(ctrl16),
    .resad(resad16), .resdt(resdt16)
  );

  function automatic logic [16:0] mk(input logic [1:0] mmrw, input logic fwr, input logic rwr,
                                     input logic [3:0] xdst, input logic [4:0] op,
                                     input logic [3:0] xsrc);
    return {mmrw, fwr, rwr, xdst, op, xsrc};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load8(input logic [3:0] dst, input logic [7:0] val);
    io_in8 = val;
    cyc(1);
    ctrl8 = mk(2'b00, 1'b0, 1'b0, dst, ALU_PASS, SRC_IPORT);
    cyc(1);
    ctrl8 = NOP;
  endtask

  task automatic mon8(input logic [7:0] ad, output logic [7:0] v);
    resad8 = ad;
    #1;
    v = resdt8;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    #1;
    checks++; if (req8 !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req8); end
    checks++; if (stall8 !== 1'b0 || we8 !== 1'b0) begin errors++; $display("FAIL reset_stall_we got %b%b exp 00", stall8, we8); end
    checks++; if (flags8 !== 4'h0) begin errors++; $display("FAIL reset_flags got %h exp 0", flags8); end
    checks++; if (io_out8 !== 8'h00 || adrs8 !== 8'h00 || i8 !== 8'h00) begin errors++; $display("FAIL reset_outs got %h %h %h exp 00 00 00", io_out8, adrs8, i8); end
    mon8(8'h00, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL reset_pc got %h exp 10", v); end
    mon8(8'h08, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_a got %h exp 00", v); end
  endtask

  task automatic test_alu();
    logic [7:0] av[8] = '{8'h7F, 8'h10, 8'h7F, 8'h81, 8'h81, 8'h05, 8'h80, 8'h01};
    logic [7:0] tv[8] = '{8'h01, 8'h20, 8'h7F, 8'h00, 8'h00, 8'h01, 8'h80, 8'h01};
    logic [4:0] op[8] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SHL, ALU_ASR, ALU_SBB, ALU_ADD, ALU_ADC};
    logic [7:0] rx[8] = '{8'h80, 8'hF0, 8'h00, 8'h02, 8'hC0, 8'h03, 8'h00, 8'h03};
    logic [3:0] fx[8] = '{4'b1100, 4'b0101, 4'b0010, 4'b0001, 4'b0101, 4'b0000, 4'b1011, 4'b0000};
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      load8(DST_A, av[k]);
      load8(DST_T, tv[k]);
      ctrl8 = mk(2'b00, 1'b1, 1'b1, 4'hF, op[k], SRC_A);
      cyc(1);
      ctrl8 = NOP;
      mon8(8'h03, v);
      checks++; if (v !== rx[k]) begin errors++; $display("FAIL alu_r[%0d] got %h exp %h", k, v, rx[k]); end
      checks++; if (flags8 !== fx[k]) begin errors++; $display("FAIL alu_flags[%0d] got %b exp %b", k, flags8, fx[k]); end
    end
  endtask

  task automatic test_regs_flg();
    logic [7:0] v;
    load8(DST_I, 8'h96);
    checks++; if (i8 !== 8'h96) begin errors++; $display("FAIL reg_i got %h exp 96", i8); end
    load8(DST_OPORT, 8'hA5);
    checks++; if (io_out8 !== 8'hA5) begin errors++; $display("FAIL reg_oport got %h exp a5", io_out8); end
    load8(DST_B, 8'h11);
    mon8(8'h09, v);
    checks++; if (v !== 8'h11) begin errors++; $display("FAIL reg_b got %h exp 11", v); end
    io_in8 = 8'h1F;
    cyc(1);
    ctrl8 = mk(2'b00, 1'b1, 1'b0, DST_FLG, ALU_PASS, SRC_IPORT);
    cyc(1);
    ctrl8 = NOP;
    mon8(8'h0D, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL flg_fwr_wins got %h exp 01", v); end
    load8(DST_FLG, 8'h1E);
    mon8(8'h0D, v);
    checks++; if (v !== 8'h1E || flags8 !== 4'hF) begin errors++; $display("FAIL flg_write got %h/%h exp 1e/f", v, flags8); end
    load8(DST_FLG, 8'h00);
    checks++; if (flags8 !== 4'h0) begin errors++; $display("FAIL flg_clear got %h exp 0", flags8); end
  endtask

  task automatic test_read();
    logic [7:0] v;
    int cnt;
    load8(DST_MAR, 8'h20);
    checks++; if (adrs8 !== 8'h20) begin errors++; $display("FAIL rd_adrs got %h exp 20", adrs8); end
    data_in8 = 8'h5A;
    ctrl8 = mk(2'b10, 1'b0, 1'b0, 4'hF, ALU_PASS, SRC_PC);
    cyc(1);
    ctrl8 = NOP;
    checks++; if (req8 !== 1'b1 || we8 !== 1'b0) begin errors++; $display("FAIL rd_req got %b%b exp 10", req8, we8); end
    cnt = 0;
    while (stall8 && cnt < 10) begin
      cnt++;
      if (cnt == 3) ack8 = 1'b1;
      cyc(1);
    end
    ack8 = 1'b0;
    checks++; if (cnt !== 3) begin errors++; $display("FAIL rd_stall_cycles got %0d exp 3", cnt); end
    mon8(8'h06, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL rd_rdr got %h exp 5a", v); end
    mon8(8'h10, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rd_state got %h exp 00", v); end
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    int cnt;
    data_in8 = 8'hC3;
    ctrl8 = mk(2'b10, 1'b0, 1'b0, 4'hF, ALU_PASS, SRC_PC);
    cyc(1);
    ctrl8 = NOP;
    cnt = 0;
    while (stall8 && cnt < 20) begin
      cnt++;
      cyc(1);
    end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL to_cycles got %0d exp 4", cnt); end
    mon8(8'h0D, v);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL to_mem_err got %b exp 1", v[0]); end
    mon8(8'h06, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL to_rdr got %h exp 5a", v); end
    cyc(2);
    mon8(8'h0D, v);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b exp 1", v[0]); end
    load8(DST_FLG, 8'h00);
    mon8(8'h0D, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL to_err_clear got %h exp 00", v); end
  endtask

  task automatic test_write_stall();
    logic [7:0] v;
    load8(DST_A, 8'h00);
    load8(DST_WDR, 8'h3C);
    checks++; if (data_out8 !== 8'h3C) begin errors++; $display("FAIL wr_data_out got %h exp 3c", data_out8); end
    ctrl8 = mk(2'b01, 1'b0, 1'b0, 4'hF, ALU_PASS, SRC_PC);
    cyc(1);
    ctrl8 = mk(2'b00, 1'b0, 1'b0, DST_A, ALU_PASS, 4'd7);
    checks++; if (we8 !== 1'b1 || req8 !== 1'b1) begin errors++; $display("FAIL wr_we got %b%b exp 11", we8, req8); end
    cyc(1);
    mon8(8'h08, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wr_a_frozen got %h exp 00", v); end
    ack8 = 1'b1;
    cyc(1);
    ack8 = 1'b0;
    mon8(8'h08, v);
    checks++; if (stall8 !== 1'b0 || v !== 8'h00) begin errors++; $display("FAIL wr_ack_edge got %b/%h exp 0/00", stall8, v); end
    cyc(1);
    ctrl8 = NOP;
    mon8(8'h08, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL wr_a_after got %h exp ff", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    load8(DST_PC, 8'h55);
    mon8(8'h00, v);
    checks++; if (v !== 8'h55) begin errors++; $display("FAIL rm_pc_load got %h exp 55", v); end
    ctrl8 = mk(2'b10, 1'b0, 1'b0, 4'hF, ALU_PASS, SRC_PC);
    cyc(1);
    ctrl8 = NOP;
    checks++; if (req8 !== 1'b1) begin errors++; $display("FAIL rm_req_before got %b exp 1", req8); end
    rst = 1'b1;
    #1;
    checks++; if (req8 !== 1'b0 || stall8 !== 1'b0) begin errors++; $display("FAIL rm_req_async got %b%b exp 00", req8, stall8); end
    mon8(8'h00, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL rm_pc got %h exp 10", v); end
    #1;
    rst = 1'b0;
    data_in8 = 8'hEE;
    ack8 = 1'b1;
    cyc(2);
    ack8 = 1'b0;
    mon8(8'h06, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rm_rdr got %h exp 00", v); end
    mon8(8'h10, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rm_state got %h exp 00", v); end
  endtask

  task automatic test_monitor_w16();
    ctrl16 = mk(2'b10, 1'b0, 1'b0, 4'hF, ALU_PASS, SRC_PC);
    cyc(1);
    ctrl16 = NOP;
    resad16 = 8'h10;
    #1;
    checks++; if (resdt16 !== 16'h0001) begin errors++; $display("FAIL w16_state got %h exp 0001", resdt16); end
    for (int k = 0; k < 5; k++) begin
      resad16 = 8'h11;
      #1;
      checks++; if (resdt16 !== 16'(k)) begin errors++; $display("FAIL w16_wcnt[%0d] got %h exp %h", k, resdt16, 16'(k)); end
      cyc(1);
    end
    resad16 = 8'h30;
    #1;
    checks++; if (resdt16 !== 16'h0000) begin errors++; $display("FAIL w16_unmapped got %h exp 0000", resdt16); end
    ack16 = 1'b1;
    cyc(1);
    ack16 = 1'b0;
    checks++; if (req16 !== 1'b0) begin errors++; $display("FAIL w16_done got %b exp 0", req16); end
  endtask

  initial begin
    rst = 1'b0;
    io_in8 = '0; data_in8 = '0; ack8 = 1'b0; ctrl8 = NOP; resad8 = '0;
    io_in16 = '0; data_in16 = '0; ack16 = 1'b0; ctrl16 = NOP; resad16 = '0;
    test_reset();
    test_alu();
    test_regs_flg();
    test_read();
    test_timeout();
    test_write_stall();
    test_reset_mid();
    test_monitor_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
